// File: rtl/add36_sequencer.sv
// 36-bit adder that time-shares one external 9-bit ripple adder over four slices,
// carrying between slices in a local register and presenting a registered result.
module add36_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [35:0] a,
  input  logic [35:0] b,
  input  logic        cin,
  output logic [8:0]  add_a,
  output logic [8:0]  add_b,
  output logic        add_cin,
  input  logic [8:0]  add_s,
  input  logic        add_cout,
  output logic        busy,
  output logic        done,
  output logic [35:0] sum,
  output logic        cout
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state, state_nxt;
  logic [1:0]  cnt;
  logic [35:0] a_lat, b_lat;
  logic        cin_lat;
  logic        carry;

  function automatic logic [8:0] slice9(input logic [35:0] v, input logic [1:0] k);
    case (k)
      2'd0:    slice9 = v[8:0];
      2'd1:    slice9 = v[17:9];
      2'd2:    slice9 = v[26:18];
      default: slice9 = v[35:27];
    endcase
  endfunction

  // Control, carry and result; the result is cleared on reset so an aborted run leaves no partial sum
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 2'd0;
      carry <= 1'b0;
      sum   <= 36'd0;
      cout  <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (start) cnt <= 2'd0;
        RUN: begin
          case (cnt)
            2'd0:    sum[8:0]   <= add_s;
            2'd1:    sum[17:9]  <= add_s;
            2'd2:    sum[26:18] <= add_s;
            default: sum[35:27] <= add_s;
          endcase
          carry <= add_cout;
          cnt   <= cnt + 2'd1;
          if (cnt == 2'd3) cout <= add_cout;
        end
        default: ;
      endcase
    end
  end

  // Operand capture; later input changes cannot disturb a run in progress
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      a_lat   <= a;
      b_lat   <= b;
      cin_lat <= cin;
    end
  end

  always_comb begin
    state_nxt = state;
    add_a     = 9'd0;
    add_b     = 9'd0;
    add_cin   = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        busy    = 1'b1;
        add_a   = slice9(a_lat, cnt);
        add_b   = slice9(b_lat, cnt);
        add_cin = (cnt == 2'd0) ? cin_lat : carry;
        if (cnt == 2'd3) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_add36_sequencer.sv
// Bench for add36_sequencer: behavioural 9-bit shared adder plus a 37-bit
// arithmetic reference for results and per-slice adder traffic.
module tb_add36_sequencer;

  logic        clk = 1'b0;
  logic        rst, start, cin;
  logic [35:0] a, b;
  logic [8:0]  add_a, add_b, add_s;
  logic        add_cin, add_cout;
  logic        busy, done, cout;
  logic [35:0] sum;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // The shared ripple adder the block drives
  assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {9'd0, add_cin};

  add36_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_s(add_s), .add_cout(add_cout),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [36:0] ref_add(input logic [35:0] x, input logic [35:0] y, input logic c);
    return {1'b0, x} + {1'b0, y} + {36'd0, c};
  endfunction

  // Carry entering slice k, from plain arithmetic on the low 9k bits
  function automatic logic carry_in(input logic [35:0] x, input logic [35:0] y, input logic c, input int k);
    logic [36:0] m, t;
    if (k == 0) return c;
    m = (37'd1 << (9 * k)) - 37'd1;
    t = ({1'b0, x} & m) + ({1'b0, y} & m) + {36'd0, c};
    return t[9 * k];
  endfunction

  // One operation: accept, four slices, DONE, back to IDLE. With hold, start stays high
  // and the next operands (nx/ny/nc) are presented right after acceptance.
  task automatic do_op(input logic [35:0] x, input logic [35:0] y, input logic c,
                       input logic hold, input logic [35:0] nx, input logic [35:0] ny,
                       input logic nc);
    logic [36:0] r;
    r = ref_add(x, y, c);
    @(negedge clk);
    a = x; b = y; cin = c; start = 1'b1;
    @(posedge clk); #1;
    start = hold;
    a = nx; b = ny; cin = nc;
    for (int k = 0; k < 4; k++) begin
      check("busy_run", busy, 1);
      check("done_run", done, 0);
      check("add_a", add_a, 64'((x >> (9 * k)) & 36'h1FF));
      check("add_b", add_b, 64'((y >> (9 * k)) & 36'h1FF));
      check("add_cin", add_cin, carry_in(x, y, c, k));
      @(posedge clk); #1;
    end
    check("done_pulse", done, 1);
    check("busy_done", busy, 0);
    check("sum", sum, r[35:0]);
    check("cout", cout, r[36]);
    check("idle_add_a", {add_a, add_b, add_cin}, 0);
    @(posedge clk); #1;
    check("done_clear", done, 0);
    check("busy_idle", busy, 0);
    check("sum_hold", sum, r[35:0]);
    check("cout_hold", cout, r[36]);
  endtask

  initial begin
    logic [35:0] x, y, ox, oy;
    logic        c, oc;
    rst = 1'b1; start = 1'b1; a = '1; b = '1; cin = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    check("rst_adder", {add_a, add_b, add_cin}, 0);
    @(negedge clk);
    rst = 1'b0; start = 1'b0;

    do_op(36'h123456789, 36'h0FEDCBA98, 1'b0, 1'b0, 36'hABCDEF012, 36'h3, 1'b1);
    do_op(36'hFFFFFFFFF, 36'h000000001, 1'b0, 1'b0, 36'h0, 36'h0, 1'b0);
    do_op(36'h0, 36'h0, 1'b1, 1'b0, 36'hFFFFFFFFF, 36'hFFFFFFFFF, 1'b1);

    // start held high through three back-to-back operations
    do_op(36'h111111111, 36'h222222222, 1'b0, 1'b1, 36'hF0F0F0F0F, 36'h0F0F0F0F1, 1'b1);
    do_op(36'hF0F0F0F0F, 36'h0F0F0F0F1, 1'b1, 1'b1, 36'h800000000, 36'h800000000, 1'b1);
    do_op(36'h800000000, 36'h800000000, 1'b1, 1'b0, 36'h0, 36'h0, 1'b0);

    // Abort at the second RUN edge
    @(negedge clk);
    a = 36'hFFFFFFFFF; b = 36'h1; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_sum", sum, 0);
    check("abort_cout", cout, 0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("abort_no_done", done, 0);
      check("abort_idle", busy, 0);
    end
    do_op(36'h5, 36'h7, 1'b0, 1'b0, 36'h0, 36'h0, 1'b0);

    // Randomized operands, with junk on the inputs during each run
    for (int i = 0; i < 10000; i++) begin
      x  = {$urandom(), $urandom()};
      y  = {$urandom(), $urandom()};
      c  = 1'($urandom());
      ox = {$urandom(), $urandom()};
      oy = {$urandom(), $urandom()};
      oc = 1'($urandom());
      if (i % 16 == 0) x = 36'hFFFFFFFFF;
      if (i % 16 == 1) y = ~x;
      do_op(x, y, c, 1'b0, ox, oy, oc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
